// File: rtl/seq_run_detector_pkg.sv
// Shared encodings for the serial run detector: FSM states, mode codes
// and the keyed selector used to build next-state choices.
package seq_run_detector_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ZEROS = 2'b01,
    ONES  = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    MODE_BOTH = 2'b00,
    MODE_ZERO = 2'b01,
    MODE_ONE  = 2'b10,
    MODE_OFF  = 2'b11
  } mode_e;

  // Keyed two-way state selector; an unmatched key falls back to IDLE.
  function automatic state_e key_mux_state(
    input logic   key,
    input logic   key0,
    input state_e val0,
    input logic   key1,
    input state_e val1
  );
    state_e sel;
    sel = IDLE;
    if (key == key0)      sel = val0;
    else if (key == key1) sel = val1;
    return sel;
  endfunction

endpackage

// File: rtl/seq_run_detector_sat_counter.sv
// Saturating up-counter with synchronous clear. Clear and increment in the
// same cycle give a count of one (clear to zero, then count), which lets the
// run tracker restart a run on a polarity change with a single control pair.
module sat_counter #(
  parameter int              W       = 8,
  parameter logic [W-1:0]    SAT_MAX = {W{1'b1}}
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] base;
  logic [W-1:0] count_nxt;

  // Next value: optional clear, then increment unless already at the ceiling.
  always_comb begin
    base      = clr ? '0 : count;
    count_nxt = base;
    if (inc && (base != SAT_MAX)) count_nxt = base + W'(1);
  end

  // Count register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count <= '0;
    else        count <= count_nxt;
  end

endmodule

// File: rtl/seq_run_detector.sv
// Serial run detector: tracks the length of the current run of equal bits
// and flags (one cycle later) every valid bit that takes the run to the
// programmed threshold. Counts detections in a saturating counter.
//
// state | meaning
// IDLE  | no valid bit seen since reset
// ZEROS | tracking a run of 0 bits
// ONES  | tracking a run of 1 bits
module seq_run_detector
  import seq_run_detector_pkg::*;
#(
  parameter int MAX_RUN = 8,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = $clog2(MAX_RUN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in,
  input  logic [LEN_W-1:0] run_len,
  input  logic [1:0]       mode,
  input  logic             overlap,
  input  logic             clr_cnt,
  output logic             out,
  output logic             out_pol,
  output logic [LEN_W-1:0] run_cnt,
  output logic [CNT_W-1:0] match_cnt
);

  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_RUN);
  localparam logic [LEN_W-1:0] MIN_L = LEN_W'(2);

  state_e           state, state_nxt;
  logic             same;
  logic             pol_en;
  logic             hit;
  logic             restart;
  logic [LEN_W-1:0] thr;
  logic [LEN_W-1:0] run_upd;
  logic             run_inc, run_clr;
  logic             match_inc;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state, threshold, post-update run length and hit decision.
  always_comb begin
    state_nxt = state;
    if (in_valid) state_nxt = key_mux_state(in, 1'b0, ZEROS, 1'b1, ONES);

    thr = run_len;
    if (run_len < MIN_L)      thr = MIN_L;
    else if (run_len > MAX_L) thr = MAX_L;

    same = ((state == ZEROS) && !in) || ((state == ONES) && in);

    run_upd = LEN_W'(1);
    if (same) run_upd = (run_cnt == MAX_L) ? run_cnt : run_cnt + LEN_W'(1);

    pol_en = (mode == MODE_BOTH) ||
             ((mode == MODE_ZERO) && !in) ||
             ((mode == MODE_ONE)  &&  in);

    hit     = in_valid && pol_en && (run_upd >= thr);
    restart = hit && !overlap;

    // A polarity change restarts at one; a non-overlapping hit empties the run.
    run_clr   = in_valid && (!same || restart);
    run_inc   = in_valid && !restart;
    match_inc = hit && !clr_cnt;
  end

  // Registered detection flag; polarity holds the last detected run's bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out     <= 1'b0;
      out_pol <= 1'b0;
    end else begin
      out <= hit;
      if (hit) out_pol <= in;
    end
  end

  sat_counter #(
    .W       (LEN_W),
    .SAT_MAX (MAX_L)
  ) u_run_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (run_inc),
    .clr   (run_clr),
    .count (run_cnt)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (match_inc),
    .clr   (clr_cnt),
    .count (match_cnt)
  );

endmodule

// File: tb/tb_seq_run_detector.sv
// Directed bench for seq_run_detector: a vector table of bit-by-bit
// expectations plus a hand-written asynchronous reset sequence. A second
// instance with a 2-bit detection counter shares the stimulus.
module tb_seq_run_detector;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vld = 1'b0;
  logic       din = 1'b0;
  logic [3:0] len = 4'd4;
  logic [1:0] md = 2'b00;
  logic       ovl = 1'b1;
  logic       clr = 1'b0;

  logic       out_a, pol_a, out_b, pol_b;
  logic [3:0] run_a, run_b;
  logic [7:0] match_a;
  logic [1:0] match_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seq_run_detector #(.MAX_RUN(8), .CNT_W(8)) u_dut (
    .clk(clk), .reset(rst_n), .in_valid(vld), .in(din), .run_len(len),
    .mode(md), .overlap(ovl), .clr_cnt(clr),
    .out(out_a), .out_pol(pol_a), .run_cnt(run_a), .match_cnt(match_a)
  );

  seq_run_detector #(.MAX_RUN(8), .CNT_W(2)) u_dut2 (
    .clk(clk), .reset(rst_n), .in_valid(vld), .in(din), .run_len(len),
    .mode(md), .overlap(ovl), .clr_cnt(clr),
    .out(out_b), .out_pol(pol_b), .run_cnt(run_b), .match_cnt(match_b)
  );

  typedef struct {
    bit       rst;
    bit [1:0] mode;
    bit       ovl;
    bit [3:0] len;
    bit       vld;
    bit       b;
    bit       clr;
    bit       eo;
    bit       ep;
    int       er;
    int       em;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void add(input bit rst, input bit [1:0] mode, input bit o,
                              input bit [3:0] l, input bit v, input bit b,
                              input bit c, input bit eo, input bit ep,
                              input int er, input int em);
    vec_t r;
    r.rst = rst; r.mode = mode; r.ovl = o; r.len = l; r.vld = v; r.b = b;
    r.clr = c; r.eo = eo; r.ep = ep; r.er = er; r.em = em;
    tbl.push_back(r);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    vld   = 1'b0;
    clr   = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic apply(input vec_t r, input int idx);
    string tag;
    @(negedge clk);
    md = r.mode; ovl = r.ovl; len = r.len; vld = r.vld; din = r.b; clr = r.clr;
    @(posedge clk);
    #1;
    tag = $sformatf("vec%0d", idx);
    check({tag, "_out"}, int'(out_a), int'(r.eo));
    if (r.eo) check({tag, "_pol"}, int'(pol_a), int'(r.ep));
    check({tag, "_run"}, int'(run_a), r.er);
    check({tag, "_match"}, int'(match_a), r.em);
    check({tag, "_match2"}, int'(match_b), (r.em > 3) ? 3 : r.em);
    check({tag, "_out2"}, int'(out_b), int'(r.eo));
  endtask

  initial begin
    // A: both polarities, overlap, threshold 4, zeros then a one; idle cycle after first hit
    add(1, 2'b00, 1, 4, 1, 0, 0, 0, 0, 1, 0);
    add(0, 2'b00, 1, 4, 1, 0, 0, 0, 0, 2, 0);
    add(0, 2'b00, 1, 4, 1, 0, 0, 0, 0, 3, 0);
    add(0, 2'b00, 1, 4, 1, 0, 0, 1, 0, 4, 1);
    add(0, 2'b00, 1, 4, 0, 1, 0, 0, 0, 4, 1);
    add(0, 2'b00, 1, 4, 1, 0, 0, 1, 0, 5, 2);
    add(0, 2'b00, 1, 4, 1, 1, 0, 0, 0, 1, 2);
    // B: no overlap, eight ones -> hits on bits 4 and 8
    add(1, 2'b00, 0, 4, 1, 1, 0, 0, 0, 1, 0);
    add(0, 2'b00, 0, 4, 1, 1, 0, 0, 0, 2, 0);
    add(0, 2'b00, 0, 4, 1, 1, 0, 0, 0, 3, 0);
    add(0, 2'b00, 0, 4, 1, 1, 0, 1, 1, 0, 1);
    add(0, 2'b00, 0, 4, 1, 1, 0, 0, 0, 1, 1);
    add(0, 2'b00, 0, 4, 1, 1, 0, 0, 0, 2, 1);
    add(0, 2'b00, 0, 4, 1, 1, 0, 0, 0, 3, 1);
    add(0, 2'b00, 0, 4, 1, 1, 0, 1, 1, 0, 2);
    // C: zeros only; six ones ignored, hit on the fourth zero
    for (int i = 1; i <= 6; i++) add(i == 1, 2'b01, 1, 4, 1, 1, 0, 0, 0, i, 0);
    for (int i = 1; i <= 4; i++) add(0, 2'b01, 1, 4, 1, 0, 0, i == 4, 0, i, int'(i == 4));
    // C2: detection off, same pattern, tracking continues
    for (int i = 1; i <= 6; i++) add(i == 1, 2'b11, 1, 4, 1, 1, 0, 0, 0, i, 0);
    for (int i = 1; i <= 4; i++) add(0, 2'b11, 1, 4, 1, 0, 0, 0, 0, i, 0);
    // C3: ones only, threshold 2
    add(1, 2'b10, 1, 2, 1, 0, 0, 0, 0, 1, 0);
    add(0, 2'b10, 1, 2, 1, 0, 0, 0, 0, 2, 0);
    add(0, 2'b10, 1, 2, 1, 1, 0, 0, 0, 1, 0);
    add(0, 2'b10, 1, 2, 1, 1, 0, 1, 1, 2, 1);
    // D: run_len 0 clamps to 2
    add(1, 2'b00, 1, 0, 1, 0, 0, 0, 0, 1, 0);
    add(0, 2'b00, 1, 0, 1, 0, 0, 1, 0, 2, 1);
    // D2: run_len 15 clamps to 8, run_cnt saturates at 8
    for (int i = 1; i <= 9; i++)
      add(i == 1, 2'b00, 1, 15, 1, 0, 0, i >= 8, 0, (i > 8) ? 8 : i, (i >= 8) ? i - 7 : 0);
    // E: threshold lowered mid-run applies to the existing count
    add(1, 2'b00, 1, 8, 1, 1, 0, 0, 0, 1, 0);
    add(0, 2'b00, 1, 8, 1, 1, 0, 0, 0, 2, 0);
    add(0, 2'b00, 1, 8, 1, 1, 0, 0, 0, 3, 0);
    add(0, 2'b00, 1, 3, 1, 1, 0, 1, 1, 4, 1);
    // F: many hits (2-bit counter saturates), then clear coincident with a hit
    for (int i = 1; i <= 7; i++) add(i == 1, 2'b00, 1, 2, 1, 0, 0, i >= 2, 0, i, (i >= 2) ? i - 1 : 0);
    add(0, 2'b00, 1, 2, 1, 0, 1, 1, 0, 8, 0);
    add(0, 2'b00, 1, 2, 1, 0, 0, 1, 0, 8, 1);

    // reset state
    #1;
    check("rst_out", int'(out_a), 0);
    check("rst_pol", int'(pol_a), 0);
    check("rst_run", int'(run_a), 0);
    check("rst_match", int'(match_a), 0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      apply(tbl[i], i);
    end

    // Asynchronous reset mid-run: three zeros (hit at threshold 3), then reset mid-cycle
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      md = 2'b00; ovl = 1'b1; len = 4'd3; vld = 1'b1; din = 1'b0; clr = 1'b0;
      @(posedge clk);
      #1;
    end
    check("pre_rst_out", int'(out_a), 1);
    check("pre_rst_run", int'(run_a), 3);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_out", int'(out_a), 0);
    check("async_pol", int'(pol_a), 0);
    check("async_run", int'(run_a), 0);
    check("async_match", int'(match_a), 0);
    @(negedge clk);
    rst_n = 1'b1;
    len = 4'd4;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("post_rst_out%0d", i), int'(out_a), int'(i == 4));
      check($sformatf("post_rst_run%0d", i), int'(run_a), i);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_run_detector.md
SEQ_RUN_DETECTOR -- requirements
Module: seq_run_detector

Interface
REQ-001 Parameter: MAX_RUN, 8, largest supported run length (>=2).
REQ-002 Parameter: CNT_W, 8, width of the detection counter.
REQ-003 Parameter: LEN_W, $clog2(MAX_RUN+1), width of run_len and run_cnt.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-006 in_valid  input  1  qualifies in; state holds when 0.
REQ-007 in  input  1  serial data bit.
REQ-008 run_len  input  LEN_W  required run length, sampled every valid cycle.
REQ-009 mode  input  2  00 both polarities, 01 zeros only, 10 ones only, 11 detection disabled.
REQ-010 overlap  input  1  1: out held for every bit beyond the threshold; 0: run restarts after each hit.
REQ-011 clr_cnt  input  1  synchronous clear of match_cnt.
REQ-012 out  output  1  registered detection flag.
REQ-013 out_pol  output  1  polarity of the run that caused the current out.
REQ-014 run_cnt  output  LEN_W  current run length, saturating at MAX_RUN.
REQ-015 match_cnt  output  CNT_W  saturating count of detections.

Function
REQ-016 FSM states: IDLE (no bit seen), ZEROS (tracking a run of 0), ONES (tracking a run of 1).
REQ-017 IDLE + valid in=b -> ZEROS/ONES per b, run_cnt=1.
REQ-018 ZEROS/ONES + valid same bit -> same state, run_cnt+1 saturating at MAX_RUN.
REQ-019 ZEROS/ONES + valid opposite bit -> opposite state, run_cnt=1.
REQ-020 Effective threshold = run_len clamped to [2, MAX_RUN].
REQ-021 Hit: valid bit brings run_cnt (post-update) >= threshold, polarity enabled by mode.
REQ-022 out and out_pol update in the cycle following the sampled bit (latency 1); out=0 in any cycle without a hit.
REQ-023 overlap=1: hit for every valid bit while run_cnt >= threshold (11111 with threshold 4 -> out on bits 4 and 5).
REQ-024 overlap=0: on hit, run_cnt resets to 0 while state is kept, so next hit requires threshold further same bits.
REQ-025 mode=11: FSM and run_cnt still track; out never asserts; match_cnt unchanged.
REQ-026 match_cnt increments by 1 per hit, saturates at 2^CNT_W-1.
REQ-027 clr_cnt and hit in same cycle: clear wins, match_cnt=0.
REQ-028 in_valid=0: state, run_cnt, match_cnt hold; out=0 next cycle.
REQ-029 Change of run_len/mode mid-run applies from the next valid bit using existing run_cnt.

Reset
REQ-030 reset=0 forces asynchronously: state=IDLE, run_cnt=0, match_cnt=0, out=0, out_pol=0.
REQ-031 Reset mid-run discards the run; first valid bit after release starts from IDLE.
REQ-032 Reset release takes effect at the next rising edge of clk; no output glitch on release.

Structure
REQ-033 Shared package holds state encodings (IDLE, ZEROS, ONES) and mode encodings (MODE_BOTH, MODE_ZERO, MODE_ONE, MODE_OFF).
REQ-034 One sub-module: sat_counter (parametrised width, async active-low reset, inc, clr, saturate), instanced for run_cnt and match_cnt.
REQ-035 Next-state and output selection built from the existing key-mux library block, with IDLE as default.

Verification
REQ-036 MAX_RUN=8, run_len=4, mode=00, overlap=1, in=0,0,0,0,0,1 -> out=1 after bits 4 and 5, out_pol=0, match_cnt=2.
REQ-037 Same config, overlap=0, in=1 x8 -> out=1 after bits 4 and 8 only, out_pol=1, match_cnt=2.
REQ-038 mode=01, in=1 x6 then 0 x4 -> single hit after bit 10, out_pol=0; mode=11 repeat -> no out, run_cnt=4.
REQ-039 run_len=0 and run_len=15 -> thresholds 2 and 8; in=0,0 gives hit; in=0 x9 gives hit only from bit 8.
REQ-040 CNT_W=2, 5 hits -> match_cnt=3; clr_cnt coincident with hit -> match_cnt=0.
REQ-041 reset=0 asserted after 3 zeros mid-cycle -> outputs 0 immediately; after release, 4 further zeros needed for hit.
